uart_baud_gen: RTL and testbench

//  Parametrised baud/oversample timing generator for UART TX/RX datapaths.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_gen_if.sv | 29 ++
 rtl/uart_frac_acc.sv | 35 +++
 rtl/uart_baud_gen.sv | 102 ++++++++++
 tb/tb_uart_baud_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the baud generator and its bench.
package uart_pkg;

  typedef struct packed {
    logic [15:0] div;
    logic [3:0]  frac;
  } baud_cfg_t;

  localparam int unsigned UART_MIN_DIV = 2;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and timing-strobe bundle between a UART datapath (master) and the baud generator (slave).
interface uart_baud_gen_if #(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned OverSample = 16,
  parameter int unsigned FracBits   = 4
);
  localparam int unsigned IdxWidth = $clog2(OverSample);

  logic                i_en;
  logic                i_restart;
  logic [CntWidth-1:0] i_div;
  logic [FracBits-1:0] i_frac;
  logic                o_os_tick;
  logic                o_mid;
  logic                o_bit;
  logic [IdxWidth-1:0] o_os_idx;
  logic                o_cfg_err;

  modport master (
    output i_en, i_restart, i_div, i_frac,
    input  o_os_tick, o_mid, o_bit, o_os_idx, o_cfg_err
  );

  modport slave (
    input  i_en, i_restart, i_div, i_frac,
    output o_os_tick, o_mid, o_bit, o_os_idx, o_cfg_err
  );

endinterface

// File: rtl/uart_frac_acc.sv
// Fractional divisor accumulator: adds i_frac at each prescale wrap and holds the
// carry-out so the following prescale period is stretched by one clock.
module uart_frac_acc #(
  parameter int unsigned FracBits = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_step,
  input  logic [FracBits-1:0] i_frac,
  output logic                o_carry
);

  logic [FracBits-1:0] r_acc;
  logic                r_carry;
  logic [FracBits:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_step) begin
      r_acc   <= w_sum[FracBits-1:0];
      r_carry <= w_sum[FracBits];
    end
  end

  assign o_carry = r_carry;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud/oversample timing generator with registered tick, mid-bit and end-of-bit strobes.
// Define UART_BAUDGEN_FRAC_EN to enable the fractional divisor (uart_frac_acc).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned OverSample = 16,
  parameter int unsigned FracBits   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_baud_gen_if.slave bus
);

  localparam int unsigned IdxWidth = $clog2(OverSample);
  localparam logic [CntWidth-1:0] MinDiv  = CntWidth'(UART_MIN_DIV);
  localparam logic [IdxWidth-1:0] IdxMid  = IdxWidth'(OverSample / 2 - 1);
  localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(OverSample - 1);

  typedef logic [CntWidth:0] ext_t;

  logic [CntWidth-1:0] r_pc;
  logic [CntWidth-1:0] r_div_q;
  logic [IdxWidth-1:0] r_os_idx;
  logic                r_os_tick;
  logic                r_mid;
  logic                r_bit;
  logic                r_cfg_err;

  logic                w_div_low;
  logic [CntWidth-1:0] w_div_ld;
  logic                w_carry;
  logic                w_last;
  logic                w_wrap;
  logic [IdxWidth-1:0] w_idx_nxt;

  assign w_div_low = (bus.i_div < MinDiv);
  assign w_div_ld  = w_div_low ? MinDiv : bus.i_div;

  // Compared one bit wider so div_q + carry cannot overflow at the top of the range.
  assign w_last    = (ext_t'(r_pc) + ext_t'(1)) == (ext_t'(r_div_q) + ext_t'(w_carry));
  assign w_wrap    = bus.i_en & ~bus.i_restart & w_last;
  assign w_idx_nxt = (r_os_idx == IdxLast) ? '0 : r_os_idx + IdxWidth'(1);

`ifdef UART_BAUDGEN_FRAC_EN
  uart_frac_acc #(
    .FracBits (FracBits)
  ) u_frac_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (bus.i_restart),
    .i_step  (w_wrap),
    .i_frac  (bus.i_frac),
    .o_carry (w_carry)
  );
`else
  assign w_carry = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking would make r_mid/r_bit see a half-updated r_os_idx.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= '0;
      r_div_q   <= MinDiv;
      r_os_idx  <= '0;
      r_os_tick <= 1'b0;
      r_mid     <= 1'b0;
      r_bit     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (bus.i_restart) begin
      r_pc      <= '0;
      r_div_q   <= w_div_ld;
      r_os_idx  <= '0;
      r_os_tick <= 1'b0;
      r_mid     <= 1'b0;
      r_bit     <= 1'b0;
      if (w_div_low) r_cfg_err <= 1'b1;
    end else if (w_wrap) begin
      // Divisor is only sampled here so a mid-period change waits for the next period.
      r_pc      <= '0;
      r_div_q   <= w_div_ld;
      r_os_idx  <= w_idx_nxt;
      r_os_tick <= 1'b1;
      r_mid     <= (w_idx_nxt == IdxMid);
      r_bit     <= (w_idx_nxt == IdxLast);
      if (w_div_low) r_cfg_err <= 1'b1;
    end else begin
      if (bus.i_en) r_pc <= r_pc + CntWidth'(1);
      r_os_tick <= 1'b0;
      r_mid     <= 1'b0;
      r_bit     <= 1'b0;
    end
  end

  assign bus.o_os_tick = r_os_tick;
  assign bus.o_mid     = r_mid;
  assign bus.o_bit     = r_bit;
  assign bus.o_os_idx  = r_os_idx;
  assign bus.o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed timing scenarios plus random control traffic,
// all checked each cycle against a period-level reference model.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned OS    = 8;
  localparam int unsigned FB    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_baud_gen_if #(.CntWidth(CNT_W), .OverSample(OS), .FracBits(FB)) bus ();

  uart_baud_gen #(
    .CntWidth   (CNT_W),
    .OverSample (OS),
    .FracBits   (FB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: length of the current period, enabled clocks spent in it,
  // ticks since restart, and the running fractional remainder.
  int m_len, m_done, m_ticks, m_acc;
  bit m_tick, m_mid, m_bit, m_err;

  function automatic int eff_div(input int d);
    return (d < int'(UART_MIN_DIV)) ? int'(UART_MIN_DIV) : d;
  endfunction

  task automatic model_reset();
    m_len = int'(UART_MIN_DIV); m_done = 0; m_ticks = 0; m_acc = 0;
    m_tick = 0; m_mid = 0; m_bit = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int d;
    int carry;
    d = int'(bus.i_div);
    carry = 0;
    m_tick = 0; m_mid = 0; m_bit = 0;
    if (bus.i_restart) begin
      m_done = 0; m_ticks = 0; m_acc = 0;
      m_len = eff_div(d);
      if (d < int'(UART_MIN_DIV)) m_err = 1;
    end else if (bus.i_en) begin
      m_done++;
      if (m_done == m_len) begin
        m_ticks++;
        m_tick = 1;
        m_mid  = ((m_ticks % OS) == OS / 2 - 1);
        m_bit  = ((m_ticks % OS) == OS - 1);
`ifdef UART_BAUDGEN_FRAC_EN
        m_acc = m_acc + int'(bus.i_frac);
        carry = m_acc / (1 << FB);
        m_acc = m_acc % (1 << FB);
`endif
        m_len  = eff_div(d) + carry;
        m_done = 0;
        if (d < int'(UART_MIN_DIV)) m_err = 1;
      end
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".tick"}, 32'(bus.o_os_tick), 32'(m_tick));
    check({tag, ".mid"},  32'(bus.o_mid),     32'(m_mid));
    check({tag, ".bit"},  32'(bus.o_bit),     32'(m_bit));
    check({tag, ".idx"},  32'(bus.o_os_idx),  32'(m_ticks % OS));
    check({tag, ".err"},  32'(bus.o_cfg_err), 32'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  function automatic bit pulse(input int sel);
    if (sel == 0) return bus.o_os_tick;
    if (sel == 1) return bus.o_mid;
    return bus.o_bit;
  endfunction

  task automatic wait_pulse(input string tag, input int sel, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!pulse(sel) && n < 200);
    if (!pulse(sel)) check({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  task automatic restart_with(input int d, input int f, input bit en);
    bus.i_div     = CNT_W'(d);
    bus.i_frac    = FB'(f);
    bus.i_en      = en;
    bus.i_restart = 1'b1;
    step("restart");
    bus.i_restart = 1'b0;
  endtask

  initial begin
    int n;
    int sum;
    baud_cfg_t cfg;

    bus.i_en = 1'b0; bus.i_restart = 1'b0; bus.i_div = CNT_W'(4); bus.i_frac = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Integer divide by 4, oversample 8.
    restart_with(4, 0, 1'b1);
    check("t1.idx0", 32'(bus.o_os_idx), 32'd0);
    wait_pulse("t1", 0, n); check("t1.first_tick", n, 4);
    wait_pulse("t1", 0, n); check("t1.tick_per", n, 4);
    wait_pulse("t1", 1, n);
    wait_pulse("t1", 1, n); check("t1.mid_per", n, 32);
    check("t1.mid_idx", 32'(bus.o_os_idx), 32'd3);
    wait_pulse("t1", 2, n);
    wait_pulse("t1", 2, n); check("t1.bit_per", n, 32);
    check("t1.bit_idx", 32'(bus.o_os_idx), 32'd7);

    // Fractional 4 + 8/16; integer-only build ignores the fraction.
    restart_with(4, 8, 1'b1);
    wait_pulse("t2", 0, n);
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      wait_pulse("t2", 0, n);
      check("t2.per_4or5", 32'(n == 4 || n == 5), 32'd1);
      sum += n;
    end
`ifdef UART_BAUDGEN_FRAC_EN
    check("t2.span32", sum, 144);
`else
    check("t2.span32", sum, 128);
`endif
    bus.i_frac = '0;

    // Divisor change mid-period.
    restart_with(4, 0, 1'b1);
    step("t3"); step("t3");
    bus.i_div = CNT_W'(6);
    wait_pulse("t3", 0, n); check("t3.cur_per", n, 2);
    wait_pulse("t3", 0, n); check("t3.new_per1", n, 6);
    wait_pulse("t3", 0, n); check("t3.new_per2", n, 6);

    // Restart at idx 5, pc 2, with and without enable.
    for (int k = 0; k < 2; k++) begin
      restart_with(4, 0, 1'b1);
      for (int t = 0; t < 5; t++) wait_pulse("t5", 0, n);
      step("t5"); step("t5");
      check("t5.idx5", 32'(bus.o_os_idx), 32'd5);
      restart_with(4, 0, (k == 0));
      bus.i_en = 1'b1;
      check("t5.idx_after", 32'(bus.o_os_idx), 32'd0);
      wait_pulse("t5", 0, n); check("t5.next_tick", n, 4);
    end

    // Enable low mid-period and on a would-be wrap cycle.
    restart_with(4, 0, 1'b1);
    wait_pulse("t6", 0, n);
    step("t6");
    bus.i_en = 1'b0;
    repeat (10) step("t6.frz");
    check("t6.idx_held", 32'(bus.o_os_idx), 32'd1);
    bus.i_en = 1'b1;
    wait_pulse("t6", 0, n); check("t6.resume", n, 3);
    step("t6"); step("t6"); step("t6");
    bus.i_en = 1'b0;
    repeat (3) step("t6.frz");
    bus.i_en = 1'b1;
    wait_pulse("t6", 0, n); check("t6.wrap_held", n, 1);

    // Divisor below minimum: clamp and sticky error.
    restart_with(1, 0, 1'b1);
    check("t4.err_set", 32'(bus.o_cfg_err), 32'd1);
    wait_pulse("t4", 0, n); check("t4.clamp_per", n, 2);
    bus.i_div = CNT_W'(4);
    wait_pulse("t4", 0, n); check("t4.old_per", n, 2);
    wait_pulse("t4", 0, n); check("t4.new_per", n, 4);
    check("t4.err_sticky", 32'(bus.o_cfg_err), 32'd1);

    // Asynchronous reset while a tick is being shown.
    restart_with(4, 0, 1'b1);
    wait_pulse("ar", 0, n);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare("async_rst");
    @(posedge clk);
    #1 compare("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_div = CNT_W'(5);
    wait_pulse("ar", 0, n); check("ar.reset_div", n, 2);

    // Random control traffic.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg.div  = 16'($urandom_range(0, 9));
        cfg.frac = 4'($urandom_range(0, 15));
        bus.i_div  = CNT_W'(cfg.div);
        bus.i_frac = FB'(cfg.frac);
      end
      bus.i_restart = ($urandom_range(0, 59) == 0);
      bus.i_en      = ($urandom_range(0, 7) != 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
